// File: rtl/quad_enc_pkg.sv
// Shared quadrature definitions for the front-panel rotary encoder decoder.
// Direction is derived from the Gray-code position of previous vs current {a,b}.
package quad_enc_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2,
    DIR_ERR  = 2'd3
  } dir_t;

  // Position along the forward cycle 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] qs_pos(input logic [1:0] qs);
    case (qs)
      QS_00:   return 2'd0;
      QS_01:   return 2'd1;
      QS_11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    delta = qs_pos(cur) - qs_pos(prev);
    case (delta)
      2'd0:    return DIR_NONE;
      2'd1:    return DIR_UP;
      2'd3:    return DIR_DN;
      default: return DIR_ERR;
    endcase
  endfunction

endpackage

// File: rtl/contact_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one encoder contact.
// A new level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
module contact_debounce #(
  parameter int   DEB_CYCLES = 1000,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt   <= '0;
      level <= RST_VAL;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Rotary encoder front end: debounced A/B, quadrature decode, sub-step accumulation
// into detents, and a bounded detent counter that saturates or wraps.
module quad_encoder_counter #(
  parameter int         CNT_W           = 4,
  parameter int         CNT_MAX         = 15,
  parameter int         CNT_INIT        = 0,
  parameter bit         WRAP            = 1'b0,
  parameter int         DEB_CYCLES      = 1000,
  parameter int         STEP_PER_DETENT = 4,
  parameter logic [1:0] IDLE_AB         = 2'b11
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [CNT_W-1:0] num,
  output logic             step_up,
  output logic             step_dn,
  output logic             err
);

  import quad_enc_pkg::*;

  localparam logic [CNT_W-1:0]  MAX_V  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]  INIT_V = CNT_W'(CNT_INIT);
  localparam logic signed [3:0] SPD    = 4'(STEP_PER_DETENT);

  logic a_lvl;
  logic b_lvl;
  logic [1:0] ab;
  logic [1:0] ab_prev;
  dir_t dir;

  logic signed [3:0] acc;
  logic signed [3:0] acc_sum;
  logic signed [3:0] acc_next;
  logic det_up;
  logic det_dn;
  logic [CNT_W-1:0] num_next;

  contact_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(IDLE_AB[1])) u_deb_a (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .raw      (a),
    .level    (a_lvl)
  );

  contact_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(IDLE_AB[0])) u_deb_b (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .raw      (b),
    .level    (b_lvl)
  );

  assign ab = {a_lvl, b_lvl};

  always_comb begin
    dir = quad_dir(ab_prev, ab);
  end

  // Accumulator stays strictly inside (-SPD, +SPD) between cycles, so the sum
  // can only touch the limits, never pass them.
  always_comb begin
    acc_sum  = acc;
    acc_next = acc;
    det_up   = 1'b0;
    det_dn   = 1'b0;
    case (dir)
      DIR_UP:  acc_sum = acc + 4'sd1;
      DIR_DN:  acc_sum = acc - 4'sd1;
      default: acc_sum = acc;
    endcase
    acc_next = acc_sum;
    if (acc_sum == SPD) begin
      det_up   = 1'b1;
      acc_next = '0;
    end else if (acc_sum == -SPD) begin
      det_dn   = 1'b1;
      acc_next = '0;
    end
  end

  always_comb begin
    num_next = num;
    if (det_up) begin
      if (num == MAX_V) num_next = WRAP ? '0 : num;
      else              num_next = num + 1'b1;
    end else if (det_dn) begin
      if (num == '0) num_next = WRAP ? MAX_V : num;
      else           num_next = num - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ab_prev <= IDLE_AB;
      err     <= 1'b0;
    end else begin
      ab_prev <= ab;
      err     <= (dir == DIR_ERR);
    end
  end

  // clr wins over a same-cycle detent: the detent and its pulse are dropped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      num     <= INIT_V;
      acc     <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else if (clr) begin
      num     <= INIT_V;
      acc     <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      num     <= num_next;
      acc     <= acc_next;
      step_up <= det_up;
      step_dn <= det_dn;
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter: one saturating and one wrapping instance
// share the same encoder stimulus; pulses are checked cycle by cycle after each edge.
module tb_quad_encoder_counter;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic a         = 1'b1;
  logic b         = 1'b1;
  logic clr       = 1'b0;

  logic [3:0] num_s, num_w;
  logic up_s, dn_s, err_s, up_w, dn_w, err_w;

  int checks = 0;
  int errors = 0;

  int         acc_m;
  int         num_sm;
  int         num_wm;
  logic [1:0] ab_m;

  always #5 sys_clk = ~sys_clk;

  quad_encoder_counter #(
    .CNT_W(4), .CNT_MAX(15), .CNT_INIT(0), .WRAP(1'b0),
    .DEB_CYCLES(4), .STEP_PER_DETENT(4), .IDLE_AB(2'b11)
  ) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .a(a), .b(b), .clr(clr),
    .num(num_s), .step_up(up_s), .step_dn(dn_s), .err(err_s)
  );

  quad_encoder_counter #(
    .CNT_W(4), .CNT_MAX(15), .CNT_INIT(0), .WRAP(1'b1),
    .DEB_CYCLES(4), .STEP_PER_DETENT(4), .IDLE_AB(2'b11)
  ) dut_wrap (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .a(a), .b(b), .clr(clr),
    .num(num_w), .step_up(up_w), .step_dn(dn_w), .err(err_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_ab(input logic [1:0] cur, input int d);
    int p;
    case (cur)
      2'b00:   p = 0;
      2'b01:   p = 1;
      2'b11:   p = 2;
      default: p = 3;
    endcase
    p = (p + d + 4) % 4;
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [5:0] pulses();
    return {up_s, dn_s, err_s, up_w, dn_w, err_w};
  endfunction

  task automatic check_nums(input string tag);
    chk({tag, "_num_sat"}, 32'(num_s), 32'(num_sm));
    chk({tag, "_num_wrap"}, 32'(num_w), 32'(num_wm));
  endtask

  // Inputs were driven on the preceding negedge; the result is due on posedge 7.
  task automatic watch(input string tag, input logic [2:0] exp7, input logic clr7);
    for (int i = 1; i <= 8; i++) begin
      @(posedge sys_clk);
      #1;
      chk(tag, 32'(pulses()), (i == 7) ? 32'({exp7, exp7}) : 32'd0);
      if (clr7 && i == 6) clr = 1'b1;
      if (clr7 && i == 7) clr = 1'b0;
    end
    check_nums(tag);
  endtask

  task automatic sub_step(input int d, input logic clr7);
    logic [2:0] e;
    int s;
    @(negedge sys_clk);
    ab_m = next_ab(ab_m, d);
    a = ab_m[1];
    b = ab_m[0];
    e = 3'b000;
    s = acc_m + d;
    if (s == 4) begin
      s = 0;
      e = 3'b100;
      num_sm = (num_sm == 15) ? 15 : num_sm + 1;
      num_wm = (num_wm == 15) ? 0 : num_wm + 1;
    end else if (s == -4) begin
      s = 0;
      e = 3'b010;
      num_sm = (num_sm == 0) ? 0 : num_sm - 1;
      num_wm = (num_wm == 0) ? 15 : num_wm - 1;
    end
    acc_m = s;
    if (clr7) begin
      e      = 3'b000;
      acc_m  = 0;
      num_sm = 0;
      num_wm = 0;
    end
    watch((d > 0) ? "fwd" : "rev", e, clr7);
  endtask

  task automatic steps(input int n, input int d);
    for (int k = 0; k < n; k++) sub_step(d, 1'b0);
  endtask

  initial begin
    acc_m  = 0;
    num_sm = 0;
    num_wm = 0;
    ab_m   = 2'b11;

    #1;
    chk("rst_pulses", 32'(pulses()), 32'd0);
    check_nums("rst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Three detents forward, then run to the top limit and beyond it.
    steps(12, 1);
    chk("three_detents", 32'(num_s), 32'd3);
    steps(48, 1);
    chk("at_max", 32'(num_s), 32'd15);
    steps(4, 1);
    chk("sat_hold", 32'(num_s), 32'd15);
    chk("wrap_to_zero", 32'(num_w), 32'd0);
    steps(4, -1);
    chk("wrap_to_max", 32'(num_w), 32'd15);

    // Three-cycle glitch on a is rejected.
    @(negedge sys_clk);
    a = ~ab_m[1];
    repeat (3) @(posedge sys_clk);
    #1 a = ab_m[1];
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk);
      #1;
      chk("glitch", 32'(pulses()), 32'd0);
    end
    check_nums("glitch");

    // Both channels flip together: 11 -> 00.
    @(negedge sys_clk);
    a = 1'b0;
    b = 1'b0;
    ab_m = 2'b00;
    watch("both_flip", 3'b001, 1'b0);

    // Reversal mid-detent cancels, then a full reverse detent.
    steps(2, 1);
    steps(2, -1);
    steps(4, -1);
    chk("rev_detent_sat", 32'(num_s), 32'd13);

    // Standalone clear.
    @(negedge sys_clk);
    clr = 1'b1;
    @(posedge sys_clk);
    #1 clr = 1'b0;
    num_sm = 0;
    num_wm = 0;
    acc_m  = 0;
    check_nums("clr");

    // clr in the same cycle a detent completes from num = 7.
    steps(28, 1);
    chk("at_seven", 32'(num_s), 32'd7);
    steps(3, 1);
    sub_step(1, 1'b1);
    steps(4, 1);
    chk("after_clr_detent", 32'(num_s), 32'd1);

    // Reset mid-detent.
    steps(2, 1);
    @(negedge sys_clk);
    ab_m = next_ab(ab_m, 1);
    a = ab_m[1];
    b = ab_m[0];
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_pulses", 32'(pulses()), 32'd0);
    num_sm = 0;
    num_wm = 0;
    acc_m  = 0;
    check_nums("midrst");
    a = 1'b1;
    b = 1'b1;
    ab_m = 2'b11;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    watch("post_rst_idle", 3'b000, 1'b0);
    steps(4, 1);
    chk("post_rst_detent", 32'(num_s), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
